// File: rtl/car_sequencer.sv
// Elevator car motion/door sequencer: IDLE/DOOR_OPEN/MOVING FSM advancing on enable ticks.
// All outputs registered; serviceValid is a one-clock pulse on DOOR_OPEN entry.
module car_sequencer #(
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  nextDirection,
  input  logic [13:0] floorButton,
  input  logic [7:1]  internalButton,
  output logic [2:0]  currentFloor,
  output logic [1:0]  currentDirection,
  output logic        doorState,
  output logic        move,
  output logic        serviceValid,
  output logic [2:0]  serviceFloor,
  output logic [1:0]  serviceDir
);

  localparam int CMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] STOP = 2'b00;
  localparam logic [1:0] UP   = 2'b10;
  localparam logic [1:0] DOWN = 2'b01;

  typedef enum logic [1:0] {IDLE, DOOR_OPEN, MOVING} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_floor;
  logic [1:0]    r_dir;
  logic          r_door;
  logic          r_move;
  logic          r_svc_vld;
  logic [2:0]    r_svc_floor;
  logic [1:0]    r_svc_dir;

  logic [7:0]  w_car_vec;
  logic [15:0] w_hall_vec;
  logic        w_car_call;
  logic [1:0]  w_hall;
  logic [1:0]  w_next_raw;
  logic [1:0]  w_next;
  logic        w_stop_here;

  // Pad the call vectors so the floor number indexes them directly.
  assign w_car_vec  = {internalButton, 1'b0};
  assign w_hall_vec = {floorButton, 2'b00};
  assign w_car_call = w_car_vec[r_floor];
  assign w_hall     = w_hall_vec[{r_floor, 1'b0} +: 2];

  // A request that would leave the shaft is folded into STOP.
  assign w_next_raw = (nextDirection == 2'b11) ? STOP : nextDirection;
  assign w_next     = ((w_next_raw == UP && r_floor == 3'd7) ||
                       (w_next_raw == DOWN && r_floor == 3'd1)) ? STOP : w_next_raw;

  assign w_stop_here = w_car_call ||
                       (r_dir == UP   && w_hall[1]) ||
                       (r_dir == DOWN && w_hall[0]) ||
                       (r_dir == STOP && (|w_hall));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_floor     <= 3'd1;
      r_dir       <= STOP;
      r_door      <= 1'b0;
      r_move      <= 1'b0;
      r_svc_vld   <= 1'b0;
      r_svc_floor <= 3'd1;
      r_svc_dir   <= 2'b00;
    end else begin
      r_svc_vld <= 1'b0;
      if (enable) begin
        case (r_state)
          IDLE: begin
            if (w_stop_here) begin
              r_state     <= DOOR_OPEN;
              r_cnt       <= CW'(DOOR_TICKS);
              r_door      <= 1'b1;
              r_svc_vld   <= 1'b1;
              r_svc_floor <= r_floor;
              r_svc_dir   <= (r_dir == STOP) ? 2'b11 : r_dir;
            end else if (w_next != r_dir) begin
              r_dir <= w_next;
            end else if (w_next != STOP) begin
              r_state <= MOVING;
              r_cnt   <= CW'(FLOOR_TICKS);
              r_move  <= 1'b1;
            end
          end
          DOOR_OPEN: begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_door  <= 1'b0;
              r_state <= IDLE;
            end
          end
          MOVING: begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              if (r_dir == UP && r_floor != 3'd7)
                r_floor <= r_floor + 3'd1;
              else if (r_dir == DOWN && r_floor != 3'd1)
                r_floor <= r_floor - 3'd1;
              r_move  <= 1'b0;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign currentFloor     = r_floor;
  assign currentDirection = r_dir;
  assign doorState        = r_door;
  assign move             = r_move;
  assign serviceValid     = r_svc_vld;
  assign serviceFloor     = r_svc_floor;
  assign serviceDir       = r_svc_dir;

endmodule

// File: tb/tb_car_sequencer.sv
// Bench for car_sequencer: behavioural Director and call latches drive the car;
// expected service pulses are queued when calls are placed and matched on serviceValid.
module tb_car_sequencer;

  localparam int FT = 4;
  localparam int DT = 6;
  localparam logic [1:0] STOP = 2'b00;
  localparam logic [1:0] UP   = 2'b10;
  localparam logic [1:0] DOWN = 2'b01;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  nextDirection;
  logic [13:0] floorButton;
  logic [7:1]  internalButton;
  logic [2:0]  currentFloor;
  logic [1:0]  currentDirection;
  logic        doorState;
  logic        move;
  logic        serviceValid;
  logic [2:0]  serviceFloor;
  logic [1:0]  serviceDir;

  car_sequencer #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .nextDirection    (nextDirection),
    .floorButton      (floorButton),
    .internalButton   (internalButton),
    .currentFloor     (currentFloor),
    .currentDirection (currentDirection),
    .doorState        (doorState),
    .move             (move),
    .serviceValid     (serviceValid),
    .serviceFloor     (serviceFloor),
    .serviceDir       (serviceDir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] floor;
    logic [1:0] dir;
    int         tick;
  } svc_t;

  svc_t       svc_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         tick        = 0;
  int         cyc         = 0;
  logic       force_en    = 1'b0;
  logic [1:0] force_val   = STOP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d (tick %0d)", tag, obs, exp, tick);
    end
  endtask

  function automatic logic calls_at(input int f);
    return internalButton[f] | floorButton[2*f-1] | floorButton[2*f-2];
  endfunction

  function automatic logic [1:0] director(input logic [2:0] fl, input logic [1:0] dr);
    logic above = 1'b0;
    logic below = 1'b0;
    for (int f = 1; f <= 7; f++) begin
      if (f > int'(fl) && calls_at(f)) above = 1'b1;
      if (f < int'(fl) && calls_at(f)) below = 1'b1;
    end
    if (dr == UP && above)   return UP;
    if (dr == DOWN && below) return DOWN;
    if (above)               return UP;
    if (below)               return DOWN;
    return STOP;
  endfunction

  task automatic push_svc(input logic [2:0] f, input logic [1:0] d, input int t);
    svc_t e;
    e.floor = f;
    e.dir   = d;
    e.tick  = t;
    svc_q.push_back(e);
  endtask

  task automatic service_check();
    svc_t e;
    if (serviceValid) begin
      if (svc_q.size() == 0) begin
        chk("svc_unexpected", 32'd1, 32'd0);
      end else begin
        e = svc_q.pop_front();
        chk("svc_floor", 32'(serviceFloor), 32'(e.floor));
        chk("svc_dir",   32'(serviceDir),   32'(e.dir));
        chk("svc_tick",  32'(tick),         32'(e.tick));
      end
      internalButton[serviceFloor] = 1'b0;
      if (serviceDir[1]) floorButton[2*serviceFloor-1] = 1'b0;
      if (serviceDir[0]) floorButton[2*serviceFloor-2] = 1'b0;
    end
  endtask

  task automatic tick_once();
    logic [1:0] dnew;
    dnew   = director(currentFloor, currentDirection);
    enable = 1'b1;
    @(posedge clk);
    #1;
    tick++;
    cyc++;
    nextDirection = force_en ? force_val : dnew;
    service_check();
  endtask

  task automatic stall_once();
    enable = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    service_check();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    reset          = 1'b0;
    nextDirection  = STOP;
    floorButton    = '0;
    internalButton = '0;
    force_en       = 1'b0;
    tick           = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_floor"}, 32'(currentFloor), 32'd1);
    chk({tag, "_dir"},   32'(currentDirection), 32'(STOP));
    chk({tag, "_door"},  32'(doorState), 32'd0);
    chk({tag, "_move"},  32'(move), 32'd0);
    chk({tag, "_svld"},  32'(serviceValid), 32'd0);
    chk({tag, "_sflr"},  32'(serviceFloor), 32'd1);
    chk({tag, "_sdir"},  32'(serviceDir), 32'd0);
  endtask

  initial begin
    int t0, d0, a0, c0;
    reset          = 1'b1;
    enable         = 1'b0;
    nextDirection  = STOP;
    floorButton    = '0;
    internalButton = '0;
    repeat (2) @(posedge clk);
    do_reset();
    check_reset_vals("rst0");

    // Car call to floor 3 from reset.
    internalButton[3] = 1'b1;
    push_svc(3'd3, UP, 13);
    for (int i = 0; i < 19; i++) begin
      tick_once();
      if (tick == 1)  chk("t1_dir_stop", 32'(currentDirection), 32'(STOP));
      if (tick == 2) begin
        chk("t2_dir_up", 32'(currentDirection), 32'(UP));
        chk("t2_hold",   32'(move), 32'd0);
      end
      if (tick == 3)  chk("t3_move", 32'(move), 32'd1);
      if (tick == 6)  chk("t6_floor1", 32'(currentFloor), 32'd1);
      if (tick == 7) begin
        chk("t7_floor2", 32'(currentFloor), 32'd2);
        chk("t7_hold",   32'(move), 32'd0);
      end
      if (tick == 12) chk("t12_floor3", 32'(currentFloor), 32'd3);
      if (tick == 13) chk("t13_door", 32'(doorState), 32'd1);
      if (tick == 18) chk("t18_door", 32'(doorState), 32'd1);
      if (tick == 19) chk("t19_close", 32'(doorState), 32'd0);
    end

    // Hall call at the resting floor.
    do_reset();
    floorButton[1:0] = 2'b01;
    push_svc(3'd1, 2'b11, 1);
    for (int i = 0; i < 9; i++) begin
      tick_once();
      chk("hc_nomove", 32'(move), 32'd0);
      if (tick == 1) chk("hc_open", 32'(doorState), 32'd1);
      if (tick == 6) chk("hc_still_open", 32'(doorState), 32'd1);
      if (tick == 7) chk("hc_close", 32'(doorState), 32'd0);
    end

    // Climb to floor 5, then reverse toward floor 2.
    t0 = tick;
    internalButton[5] = 1'b1;
    push_svc(3'd5, UP, t0 + 23);
    repeat (23) tick_once();
    chk("rv_at5_door", 32'(doorState), 32'd1);
    chk("rv_at5_floor", 32'(currentFloor), 32'd5);
    d0 = tick;
    internalButton[2] = 1'b1;
    a0 = d0 + DT + 1;
    push_svc(3'd2, DOWN, a0 + 3*FT + 4);
    while (tick < a0 + 3*FT + 4 + DT + 2) begin
      tick_once();
      if (tick == a0 - 1) begin
        chk("rv_closed", 32'(doorState), 32'd0);
        chk("rv_dir_up", 32'(currentDirection), 32'(UP));
      end
      if (tick == a0) begin
        chk("rv_dir_down", 32'(currentDirection), 32'(DOWN));
        chk("rv_hold",     32'(move), 32'd0);
      end
      if (tick == a0 + 1)          chk("rv_move", 32'(move), 32'd1);
      if (tick == a0 + 3*FT + 2)   chk("rv_floor3", 32'(currentFloor), 32'd3);
      if (tick == a0 + 3*FT + 3)   chk("rv_floor2", 32'(currentFloor), 32'd2);
    end
    chk("rv_dir_stop", 32'(currentDirection), 32'(STOP));

    // Stall ten clocks during travel from floor 2 to floor 4.
    t0 = tick;
    c0 = cyc;
    internalButton[4] = 1'b1;
    push_svc(3'd4, UP, t0 + 13);
    repeat (5) tick_once();
    chk("st_moving", 32'(move), 32'd1);
    for (int i = 0; i < 10; i++) begin
      stall_once();
      chk("st_frz_move",  32'(move), 32'd1);
      chk("st_frz_floor", 32'(currentFloor), 32'd2);
    end
    tick_once();
    chk("st_not_yet", 32'(currentFloor), 32'd2);
    tick_once();
    chk("st_arrive3", 32'(currentFloor), 32'd3);
    chk("st_arrive_cyc", 32'(cyc - c0), 32'(7 + 10));
    while (tick < t0 + 15) tick_once();
    chk("st_door4", 32'(doorState), 32'd1);
    chk("st_floor4", 32'(currentFloor), 32'd4);

    // Reset while the door is open.
    do_reset();
    check_reset_vals("rst_door");

    // Requests that would leave the shaft at floor 1.
    force_en  = 1'b1;
    force_val = DOWN;
    nextDirection = DOWN;
    repeat (4) begin
      tick_once();
      chk("bd1_nomove", 32'(move), 32'd0);
    end
    chk("bd1_dir", 32'(currentDirection), 32'(STOP));
    chk("bd1_floor", 32'(currentFloor), 32'd1);
    force_en = 1'b0;
    nextDirection = STOP;

    // Travel to the top floor, then request UP there.
    t0 = tick;
    internalButton[7] = 1'b1;
    push_svc(3'd7, UP, t0 + 33);
    repeat (33) tick_once();
    chk("bd7_door", 32'(doorState), 32'd1);
    force_en  = 1'b1;
    force_val = UP;
    nextDirection = UP;
    repeat (12) begin
      tick_once();
      chk("bd7_nomove", 32'(move), 32'd0);
      chk("bd7_floor",  32'(currentFloor), 32'd7);
    end
    chk("bd7_dir", 32'(currentDirection), 32'(STOP));
    force_en = 1'b0;

    chk("svc_pending", 32'(svc_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
